// File: rtl/payment_controller.sv
// Vending-machine payment FSM: accumulates coins into credit, dispenses once the
// latched price is covered, then pays change greedily one coin per cycle.
module payment_controller #(
   parameter int unsigned CREDIT_MAX = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] price,
   input  logic       buy,
   input  logic       cancel,
   input  logic       coin_valid,
   input  logic [1:0] coin_type,
   output logic [9:0] credit,
   output logic       busy,
   output logic       dispense,
   output logic       coin_reject,
   output logic       ret_quarter,
   output logic       ret_dime,
   output logic       ret_nickel
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      DISPENSE = 2'd2,
      CHANGE   = 2'd3
   } state_t;

   typedef struct packed {
      logic       quarter;
      logic       dime;
      logic       nickel;
      logic [9:0] rem;
   } step_t;

   function automatic logic [9:0] coin_value(input logic [1:0] kind);
      logic [9:0] v;
      case (kind)
         2'd0:    v = 10'd5;
         2'd1:    v = 10'd10;
         2'd2:    v = 10'd25;
         2'd3:    v = 10'd100;
         default: v = 10'd0;
      endcase
      return v;
   endfunction

   // One greedy change step; a 1..4 cent remainder is dropped without a pulse.
   function automatic step_t change_step(input logic [9:0] c);
      step_t s;
      s.quarter = 1'b0;
      s.dime    = 1'b0;
      s.nickel  = 1'b0;
      if (c >= 10'd25) begin
         s.quarter = 1'b1;
         s.rem     = c - 10'd25;
      end else if (c >= 10'd10) begin
         s.dime = 1'b1;
         s.rem  = c - 10'd10;
      end else if (c >= 10'd5) begin
         s.nickel = 1'b1;
         s.rem    = c - 10'd5;
      end else begin
         s.rem = 10'd0;
      end
      return s;
   endfunction

   state_t      state_r;
   logic [9:0]  price_q_r;
   logic [10:0] coin_sum_s;
   logic        coin_accept_s;
   logic        coin_reject_s;
   logic [9:0]  credit_in_s;
   step_t       step_s;

   // Coin acceptance and the next change step, both from registered credit.
   always_comb begin
      coin_sum_s = {1'b0, credit} + {1'b0, coin_value(coin_type)};
      if (coin_valid && !cancel && (state_r == IDLE || state_r == COLLECT) &&
          (coin_sum_s <= 11'(CREDIT_MAX))) begin
         coin_accept_s = 1'b1;
      end else begin
         coin_accept_s = 1'b0;
      end
      coin_reject_s = coin_valid && !coin_accept_s;
      if (coin_accept_s) begin
         credit_in_s = coin_sum_s[9:0];
      end else begin
         credit_in_s = credit;
      end
      step_s = change_step(credit);
   end

   // Main FSM with registered credit, busy and one-cycle output pulses.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= IDLE;
         price_q_r   <= 10'd0;
         credit      <= 10'd0;
         busy        <= 1'b0;
         dispense    <= 1'b0;
         coin_reject <= 1'b0;
         ret_quarter <= 1'b0;
         ret_dime    <= 1'b0;
         ret_nickel  <= 1'b0;
      end else begin
         dispense    <= 1'b0;
         ret_quarter <= 1'b0;
         ret_dime    <= 1'b0;
         ret_nickel  <= 1'b0;
         coin_reject <= coin_reject_s;
         case (state_r)
            IDLE: begin
               if (cancel && (credit != 10'd0)) begin
                  // Entering CHANGE already ejects the first coin.
                  state_r     <= CHANGE;
                  busy        <= 1'b1;
                  credit      <= step_s.rem;
                  ret_quarter <= step_s.quarter;
                  ret_dime    <= step_s.dime;
                  ret_nickel  <= step_s.nickel;
               end else if (buy && (price != 10'd0)) begin
                  state_r   <= COLLECT;
                  price_q_r <= price;
                  busy      <= 1'b0;
                  credit    <= credit_in_s;
               end else begin
                  busy   <= 1'b0;
                  credit <= credit_in_s;
               end
            end
            COLLECT: begin
               if (cancel) begin
                  state_r     <= CHANGE;
                  busy        <= 1'b1;
                  credit      <= step_s.rem;
                  ret_quarter <= step_s.quarter;
                  ret_dime    <= step_s.dime;
                  ret_nickel  <= step_s.nickel;
               end else if (credit >= price_q_r) begin
                  state_r  <= DISPENSE;
                  busy     <= 1'b1;
                  dispense <= 1'b1;
                  credit   <= credit_in_s - price_q_r;
               end else begin
                  busy   <= 1'b0;
                  credit <= credit_in_s;
               end
            end
            DISPENSE: begin
               if (credit != 10'd0) begin
                  state_r     <= CHANGE;
                  busy        <= 1'b1;
                  credit      <= step_s.rem;
                  ret_quarter <= step_s.quarter;
                  ret_dime    <= step_s.dime;
                  ret_nickel  <= step_s.nickel;
               end else begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end
            end
            CHANGE: begin
               if (credit == 10'd0) begin
                  state_r <= IDLE;
                  busy    <= 1'b0;
               end else begin
                  busy        <= 1'b1;
                  credit      <= step_s.rem;
                  ret_quarter <= step_s.quarter;
                  ret_dime    <= step_s.dime;
                  ret_nickel  <= step_s.nickel;
               end
            end
            default: begin
               state_r <= IDLE;
               busy    <= 1'b0;
               credit  <= 10'd0;
            end
         endcase
      end
   end

endmodule
